// File: rtl/radix4_ntt_pipe.sv
// Three-stage radix-4 NTT/INTT butterfly over Z_q with valid/ready flow control.
// S1 pre-multiplies (NTT), S2 runs the 4-point kernel, S3 post-multiplies (INTT).
module radix4_ntt_pipe #(
    parameter int unsigned width    = 16,
    parameter int unsigned MODULUS  = 12289,
    parameter int unsigned IMAG     = 1479,
    parameter int unsigned IMAG_INV = 10810
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             select,
    input  logic [width-1:0] input_1,
    input  logic [width-1:0] input_2,
    input  logic [width-1:0] input_3,
    input  logic [width-1:0] input_4,
    input  logic [width-1:0] input_twiddle_2,
    input  logic [width-1:0] input_twiddle_3,
    input  logic [width-1:0] input_twiddle_4,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] output_1,
    output logic [width-1:0] output_2,
    output logic [width-1:0] output_3,
    output logic [width-1:0] output_4
);

    localparam int unsigned PW = 2 * width;
    localparam int unsigned SW = width + 2;

    typedef logic [width-1:0] word_t;

    function automatic word_t mul_mod(input word_t a, input word_t b);
        logic [PW-1:0] p;
        p = PW'(a) * PW'(b);
        return word_t'(p % PW'(MODULUS));
    endfunction

    // Operands are each <= q, so four of them fit in width+2 bits.
    function automatic word_t add4_mod(input word_t a, input word_t b,
                                       input word_t c, input word_t d);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b) + SW'(c) + SW'(d);
        return word_t'(s % SW'(MODULUS));
    endfunction

    function automatic word_t neg_mod(input word_t a);
        return word_t'(MODULUS) - a;
    endfunction

    logic  advance;
    logic  s1_v_q, s2_v_q, s3_v_q;
    logic  s1_sel_q, s2_sel_q;
    word_t s1_d_q [4];
    word_t s2_d_q [4];
    word_t s3_d_q [4];
    word_t s1_d_d [4];
    word_t s2_d_d [4];
    word_t s3_d_d [4];
    word_t s1_w_q [3];
    word_t s2_w_q [3];
    word_t imag_sel;
    word_t t1;
    word_t t3;

    assign advance  = !s3_v_q || out_ready;
    assign in_ready = advance;

    // S1: twiddle pre-multiply for NTT, pass-through for INTT
    always_comb begin
        s1_d_d[0] = input_1;
        s1_d_d[1] = select ? input_2 : mul_mod(input_2, input_twiddle_2);
        s1_d_d[2] = select ? input_3 : mul_mod(input_3, input_twiddle_3);
        s1_d_d[3] = select ? input_4 : mul_mod(input_4, input_twiddle_4);
    end

    // S2: 4-point kernel, root of unity picked per beat
    always_comb begin
        imag_sel  = s1_sel_q ? word_t'(IMAG_INV) : word_t'(IMAG);
        t1        = mul_mod(s1_d_q[1], imag_sel);
        t3        = mul_mod(s1_d_q[3], imag_sel);
        s2_d_d[0] = add4_mod(s1_d_q[0], s1_d_q[1], s1_d_q[2], s1_d_q[3]);
        s2_d_d[1] = add4_mod(s1_d_q[0], t1, neg_mod(s1_d_q[2]), neg_mod(t3));
        s2_d_d[2] = add4_mod(s1_d_q[0], neg_mod(s1_d_q[1]), s1_d_q[2], neg_mod(s1_d_q[3]));
        s2_d_d[3] = add4_mod(s1_d_q[0], neg_mod(t1), neg_mod(s1_d_q[2]), t3);
    end

    // S3: twiddle post-multiply for INTT
    always_comb begin
        s3_d_d[0] = s2_d_q[0];
        for (int j = 1; j < 4; j++) begin
            s3_d_d[j] = s2_sel_q ? mul_mod(s2_d_q[j], s2_w_q[j-1]) : s2_d_q[j];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q   <= 1'b0;
            s2_v_q   <= 1'b0;
            s3_v_q   <= 1'b0;
            s1_sel_q <= 1'b0;
            s2_sel_q <= 1'b0;
            for (int j = 0; j < 4; j++) begin
                s1_d_q[j] <= '0;
                s2_d_q[j] <= '0;
                s3_d_q[j] <= '0;
            end
            for (int j = 0; j < 3; j++) begin
                s1_w_q[j] <= '0;
                s2_w_q[j] <= '0;
            end
        end else if (advance) begin
            s1_v_q    <= in_valid;
            s2_v_q    <= s1_v_q;
            s3_v_q    <= s2_v_q;
            s1_sel_q  <= select;
            s2_sel_q  <= s1_sel_q;
            s1_w_q[0] <= input_twiddle_2;
            s1_w_q[1] <= input_twiddle_3;
            s1_w_q[2] <= input_twiddle_4;
            for (int j = 0; j < 3; j++) begin
                s2_w_q[j] <= s1_w_q[j];
            end
            for (int j = 0; j < 4; j++) begin
                s1_d_q[j] <= s1_d_d[j];
                s2_d_q[j] <= s2_d_d[j];
                s3_d_q[j] <= s3_d_d[j];
            end
        end
    end

    assign out_valid = s3_v_q;
    assign output_1  = s3_d_q[0];
    assign output_2  = s3_d_q[1];
    assign output_3  = s3_d_q[2];
    assign output_4  = s3_d_q[3];

endmodule

// File: tb/tb_radix4_ntt_pipe.sv
// Directed bench for radix4_ntt_pipe: hand vectors, backpressure, mode interleave, reset.
module tb_radix4_ntt_pipe;

    localparam int unsigned W   = 16;
    localparam int unsigned Q   = 12289;
    localparam int unsigned IM  = 1479;
    localparam int unsigned IMI = 10810;

    typedef logic [3:0][W-1:0] res_t;
    typedef logic [2:0][W-1:0] tw_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         select;
    logic [W-1:0] input_1, input_2, input_3, input_4;
    logic [W-1:0] input_twiddle_2, input_twiddle_3, input_twiddle_4;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] output_1, output_2, output_3, output_4;

    radix4_ntt_pipe #(.width(W), .MODULUS(Q), .IMAG(IM), .IMAG_INV(IMI)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .select(select),
        .input_1(input_1), .input_2(input_2), .input_3(input_3), .input_4(input_4),
        .input_twiddle_2(input_twiddle_2), .input_twiddle_3(input_twiddle_3),
        .input_twiddle_4(input_twiddle_4),
        .out_valid(out_valid), .out_ready(out_ready),
        .output_1(output_1), .output_2(output_2), .output_3(output_3), .output_4(output_4)
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_out  = 0;
    int   cyc    = 0;
    bit   ov_s, acc_s, hold_s;
    res_t held, exp_hand;
    res_t exp_q[$];

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic res_t mk(input int unsigned a, input int unsigned b,
                                input int unsigned c, input int unsigned d);
        res_t r;
        r[0] = W'(a); r[1] = W'(b); r[2] = W'(c); r[3] = W'(d);
        return r;
    endfunction

    function automatic tw_t mkw(input int unsigned a, input int unsigned b, input int unsigned c);
        tw_t r;
        r[0] = W'(a); r[1] = W'(b); r[2] = W'(c);
        return r;
    endfunction

    function automatic res_t outs();
        return mk(output_1, output_2, output_3, output_4);
    endfunction

    function automatic longint unsigned pw(input longint unsigned b, input int e);
        longint unsigned r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % Q;
        return r;
    endfunction

    // Reference: y_k = sum_j a_j * I^(jk) straight from the DFT definition
    function automatic res_t model(input bit sel, input res_t x, input tw_t w);
        longint unsigned a[4];
        longint unsigned y[4];
        longint unsigned root;
        res_t r;
        root = sel ? IMI : IM;
        for (int j = 0; j < 4; j++)
            a[j] = (j == 0 || sel) ? longint'(x[j]) : (longint'(x[j]) * longint'(w[j-1])) % Q;
        for (int k = 0; k < 4; k++) begin
            y[k] = 0;
            for (int j = 0; j < 4; j++) y[k] = (y[k] + a[j] * pw(root, (j * k) % 4)) % Q;
            if (sel && k > 0) y[k] = (y[k] * longint'(w[k-1])) % Q;
            r[k] = W'(y[k]);
        end
        return r;
    endfunction

    // One cycle: observe at negedge, then cross the rising edge
    task automatic tick();
        res_t e;
        res_t cur;
        @(negedge clk);
        cur = outs();
        if (hold_s) begin
            check("hold_valid", 64'(out_valid), 1);
            for (int k = 0; k < 4; k++) check($sformatf("hold_y%0d", k), 64'(cur[k]), 64'(held[k]));
        end
        if (out_valid && !out_ready) check("stall_in_ready", 64'(in_ready), 0);
        hold_s = out_valid && !out_ready;
        held   = cur;
        ov_s   = out_valid;
        if (out_valid && out_ready) begin
            n_out++;
            check("beat_expected", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                for (int k = 0; k < 4; k++) check($sformatf("y%0d", k), 64'(cur[k]), 64'(e[k]));
            end
        end
        acc_s = in_valid && in_ready;
        if (acc_s) exp_q.push_back(exp_hand);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit sel, input res_t x, input tw_t w, input res_t exp, input bit stall_en);
        int guard = 0;
        in_valid = 1'b1;
        select   = sel;
        input_1 = x[0]; input_2 = x[1]; input_3 = x[2]; input_4 = x[3];
        input_twiddle_2 = w[0]; input_twiddle_3 = w[1]; input_twiddle_4 = w[2];
        exp_hand = exp;
        do begin
            out_ready = !(stall_en && cyc >= 4 && cyc <= 6);
            tick();
            cyc++;
            guard++;
        end while (!acc_s && guard < 50);
        check("accept", 64'(acc_s), 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && guard < 50) begin
            tick();
            guard++;
        end
        check("drain_empty", 64'(exp_q.size()), 0);
    endtask

    task automatic measure_latency(input string tag);
        int lat = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            tick();
            if (ov_s) lat = i;
        end
        check(tag, 64'(lat), 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        res_t x, e;
        tw_t  w;
        int   n0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; select = 1'b0;
        input_1 = '0; input_2 = '0; input_3 = '0; input_4 = '0;
        input_twiddle_2 = '0; input_twiddle_3 = '0; input_twiddle_4 = '0;
        hold_s = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_outputs", 64'({output_1, output_2, output_3, output_4}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 1);
        @(posedge clk);
        #1;

        // Impulse: latency and single-cycle valid
        send(1'b0, mk(1, 0, 0, 0), mkw(1, 1, 1), mk(1, 1, 1, 1), 1'b0);
        measure_latency("latency");
        tick();
        check("single_cycle_valid", 64'(ov_s), 0);

        // Unit vector in both modes, then modular wrap cases
        send(1'b0, mk(0, 1, 0, 0), mkw(1, 1, 1), mk(1, 1479, 12288, 10810), 1'b0);
        send(1'b1, mk(0, 1, 0, 0), mkw(1, 1, 1), mk(1, 10810, 12288, 1479), 1'b0);
        send(1'b0, mk(12288, 12288, 12288, 12288), mkw(1, 1, 1), mk(12285, 0, 0, 0), 1'b0);
        send(1'b0, mk(0, 2, 0, 0), mkw(6145, 1, 1), mk(1, 1479, 12288, 10810), 1'b0);
        drain();

        // Backpressure: 8 back-to-back beats, out_ready low in cycles 4..6
        n0  = n_out;
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            x = mk(i, 2 * i + 1, 3 * i + 5, 100 * i);
            w = mkw(i + 2, 7, Q - 1 - i);
            send(1'b0, x, w, model(1'b0, x, w), 1'b1);
        end
        drain();
        check("bp_beat_count", 64'(n_out - n0), 8);

        // Alternating modes on consecutive beats
        n0 = n_out;
        for (int i = 0; i < 8; i++) begin
            x = mk((i * 4099 + 17) % Q, (i * 911 + 3) % Q, Q - 1 - i, (i * 12007) % Q);
            w = mkw((i * 5003 + 1) % Q, (i * 77 + 2) % Q, Q - 2 - i);
            send(i[0], x, w, model(i[0], x, w), 1'b0);
        end
        drain();
        check("mix_beat_count", 64'(n_out - n0), 8);

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            x = mk(i + 1, i + 2, i + 3, i + 4);
            w = mkw(1, 2, 3);
            send(1'b0, x, w, model(1'b0, x, w), 1'b0);
        end
        check("inflight_valid", 64'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 64'(out_valid), 0);
        check("rst_async_y0", 64'(output_1), 0);
        exp_q.delete();
        hold_s = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_idle", 64'(ov_s), 0);
        end
        e = mk(1, 1479, 12288, 10810);
        send(1'b0, mk(0, 1, 0, 0), mkw(1, 1, 1), e, 1'b0);
        measure_latency("post_rst_latency");
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
